// File: rtl/pe_array_seq_ctrl_pkg.sv
// Shared encodings for the PE array sequencer: precision fields, FSM states,
// default alignment latencies and a saturating counter helper.
package pe_array_seq_ctrl_pkg;

   localparam logic [1:0] PREC_2B  = 2'b00;
   localparam logic [1:0] PREC_4B  = 2'b01;
   localparam logic [1:0] PREC_8B  = 2'b10;
   localparam logic [1:0] PREC_ILL = 2'b11;

   localparam int RD_LAT_DEF   = 1;
   localparam int PSUM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   // Both the activation and the weight field must name a supported width.
   function automatic logic prec_legal(input logic [3:0] prec);
      return (prec[3:2] != PREC_ILL) && (prec[1:0] != PREC_ILL);
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pe_seq_tag_pipe.sv
// Depth-N shift register with synchronous clear; delays a small tag vector
// by exactly DEPTH clock cycles.
module pe_seq_tag_pipe #(
   parameter int W     = 3,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage_q [DEPTH];
   logic [W-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Job sequencer for a 16-row bit-fusion PE array. Optional macro
// PE_SEQ_PERF_CNT_EN adds saturating busy/stall cycle counters.
module pe_array_seq_ctrl
   import pe_array_seq_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int STEP_W   = 10,
   parameter int TILE_W   = 8,
   parameter int RD_LAT   = RD_LAT_DEF,
   parameter int PSUM_LAT = PSUM_LAT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_Start,
   input  logic [3:0]        i_Precision,
   input  logic [STEP_W-1:0] i_Num_Steps,
   input  logic [TILE_W-1:0] i_Num_Tiles,
   input  logic [ADDR_W-1:0] i_Base_Addr,
   input  logic              i_Stall,
   output logic              o_Busy,
   output logic              o_Rd_En,
   output logic [ADDR_W-1:0] o_Rd_Addr,
   output logic [3:0]        o_Precision,
   output logic              o_Sel_Bias,
   output logic              o_Core_Vld,
   output logic              o_Flush,
   output logic              o_Psum_Vld,
   output logic              o_Cfg_Err,
`ifdef PE_SEQ_PERF_CNT_EN
   output logic [31:0]       o_Busy_Cycles,
   output logic [31:0]       o_Stall_Cycles,
`endif
   output logic              o_Done
);

   seq_state_e        state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cfg_err_q, cfg_err_d;
   logic [3:0]        prec_q, prec_d;
   logic [STEP_W-1:0] num_steps_q, num_steps_d, step_cnt_q, step_cnt_d;
   logic [TILE_W-1:0] num_tiles_q, num_tiles_d, tile_cnt_q, tile_cnt_d;
   logic [TILE_W-1:0] psum_cnt_q, psum_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef PE_SEQ_PERF_CNT_EN
   logic [31:0]       busy_cyc_q, busy_cyc_d, stall_cyc_q, stall_cyc_d;
`endif

   logic       rd_en, last_step, last_tile, accept;
   logic [2:0] tag_in, tag_out;
   logic       flush, psum_vld;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      prec_d      = prec_q;
      num_steps_d = num_steps_q;
      num_tiles_d = num_tiles_q;
      step_cnt_d  = step_cnt_q;
      tile_cnt_d  = tile_cnt_q;
      psum_cnt_d  = psum_cnt_q;
      addr_d      = addr_q;
      accept      = 1'b0;

      rd_en     = (state_q == ST_ISSUE) && !i_Stall;
      last_step = (step_cnt_q == num_steps_q - STEP_W'(1));
      last_tile = (tile_cnt_q == num_tiles_q - TILE_W'(1));

      // Psums from earlier tiles may retire while later tiles are still issuing.
      if (psum_vld) begin
         psum_cnt_d = psum_cnt_q + TILE_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (i_Start) begin
               if (!prec_legal(i_Precision)) begin
                  cfg_err_d = 1'b1;
               end else if (i_Num_Steps == '0 || i_Num_Tiles == '0) begin
                  accept  = 1'b1;
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  accept      = 1'b1;
                  state_d     = ST_ISSUE;
                  busy_d      = 1'b1;
                  prec_d      = i_Precision;
                  num_steps_d = i_Num_Steps;
                  num_tiles_d = i_Num_Tiles;
                  addr_d      = i_Base_Addr;
                  step_cnt_d  = '0;
                  tile_cnt_d  = '0;
                  psum_cnt_d  = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (rd_en) begin
               addr_d = addr_q + ADDR_W'(1);
               if (last_step) begin
                  step_cnt_d = '0;
                  tile_cnt_d = tile_cnt_q + TILE_W'(1);
                  if (last_tile) begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (psum_vld && (psum_cnt_q == num_tiles_q - TILE_W'(1))) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

`ifdef PE_SEQ_PERF_CNT_EN
      busy_cyc_d  = busy_cyc_q;
      stall_cyc_d = stall_cyc_q;
      if (accept) begin
         busy_cyc_d  = '0;
         stall_cyc_d = '0;
      end else begin
         if (busy_q) begin
            busy_cyc_d = sat_inc32(busy_cyc_q);
         end
         if (state_q == ST_ISSUE && i_Stall) begin
            stall_cyc_d = sat_inc32(stall_cyc_q);
         end
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         prec_q      <= '0;
         num_steps_q <= '0;
         num_tiles_q <= '0;
         step_cnt_q  <= '0;
         tile_cnt_q  <= '0;
         psum_cnt_q  <= '0;
         addr_q      <= '0;
`ifdef PE_SEQ_PERF_CNT_EN
         busy_cyc_q  <= '0;
         stall_cyc_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         prec_q      <= prec_d;
         num_steps_q <= num_steps_d;
         num_tiles_q <= num_tiles_d;
         step_cnt_q  <= step_cnt_d;
         tile_cnt_q  <= tile_cnt_d;
         psum_cnt_q  <= psum_cnt_d;
         addr_q      <= addr_d;
`ifdef PE_SEQ_PERF_CNT_EN
         busy_cyc_q  <= busy_cyc_d;
         stall_cyc_q <= stall_cyc_d;
`endif
      end
   end

   // Tags ride alongside each read so they line up with the returning operand data.
   assign tag_in = {(step_cnt_q == '0), last_step, rd_en};

   pe_seq_tag_pipe #(.W(3), .DEPTH(RD_LAT)) u_tag_pipe (
      .clk  (CLK),
      .clr  (RST),
      .din  (tag_in),
      .dout (tag_out)
   );

   assign flush = tag_out[1] & tag_out[0];

   pe_seq_tag_pipe #(.W(1), .DEPTH(PSUM_LAT)) u_psum_pipe (
      .clk  (CLK),
      .clr  (RST),
      .din  (flush),
      .dout (psum_vld)
   );

   assign o_Busy      = busy_q;
   assign o_Rd_En     = rd_en;
   assign o_Rd_Addr   = addr_q;
   assign o_Precision = prec_q;
   assign o_Sel_Bias  = tag_out[2] & tag_out[0];
   assign o_Core_Vld  = tag_out[0];
   assign o_Flush     = flush;
   assign o_Psum_Vld  = psum_vld;
   assign o_Cfg_Err   = cfg_err_q;
   assign o_Done      = done_q;
`ifdef PE_SEQ_PERF_CNT_EN
   assign o_Busy_Cycles  = busy_cyc_q;
   assign o_Stall_Cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Directed table-driven bench for pe_array_seq_ctrl (default RD_LAT=1, PSUM_LAT=2).
module tb_pe_array_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        i_Start;
   logic [3:0]  i_Precision;
   logic [9:0]  i_Num_Steps;
   logic [7:0]  i_Num_Tiles;
   logic [11:0] i_Base_Addr;
   logic        i_Stall;
   logic        o_Busy, o_Rd_En, o_Sel_Bias, o_Core_Vld, o_Flush, o_Psum_Vld, o_Cfg_Err, o_Done;
   logic [11:0] o_Rd_Addr;
   logic [3:0]  o_Precision;
`ifdef PE_SEQ_PERF_CNT_EN
   logic [31:0] o_Busy_Cycles, o_Stall_Cycles;
`endif

   int tests = 0;
   int fails = 0;

   localparam int WIN = 24;

   pe_array_seq_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .i_Start     (i_Start),
      .i_Precision (i_Precision),
      .i_Num_Steps (i_Num_Steps),
      .i_Num_Tiles (i_Num_Tiles),
      .i_Base_Addr (i_Base_Addr),
      .i_Stall     (i_Stall),
      .o_Busy      (o_Busy),
      .o_Rd_En     (o_Rd_En),
      .o_Rd_Addr   (o_Rd_Addr),
      .o_Precision (o_Precision),
      .o_Sel_Bias  (o_Sel_Bias),
      .o_Core_Vld  (o_Core_Vld),
      .o_Flush     (o_Flush),
      .o_Psum_Vld  (o_Psum_Vld),
      .o_Cfg_Err   (o_Cfg_Err),
`ifdef PE_SEQ_PERF_CNT_EN
      .o_Busy_Cycles  (o_Busy_Cycles),
      .o_Stall_Cycles (o_Stall_Cycles),
`endif
      .o_Done      (o_Done)
   );

   always #5 CLK = ~CLK;

   // Masks are indexed by cycle after the start edge (cycle 1 = first cycle
   // after i_Start is sampled); sel/flush masks are indexed by beat number.
   typedef struct {
      string       name;
      logic [3:0]  prec;
      logic [9:0]  steps;
      logic [7:0]  tiles;
      logic [11:0] base;
      int          stall_from;
      int          stall_len;
      int          restart_at;
      logic [31:0] rd_m;
      logic [31:0] core_m;
      logic [31:0] sel_b;
      logic [31:0] flush_b;
      logic [31:0] psum_m;
      logic [31:0] busy_m;
      logic [31:0] done_m;
      logic [31:0] cfg_m;
      logic [3:0]  prec_out;
   } job_t;

   job_t jobs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_job(input job_t j);
      logic [31:0] rd_m = '0, core_m = '0, sel_b = '0, flush_b = '0;
      logic [31:0] psum_m = '0, busy_m = '0, done_m = '0, cfg_m = '0;
      logic [3:0]  pout = '0;
      logic [11:0] ea;
      int nrd = 0;
      int nbeat = 0;
      @(negedge CLK);
      i_Precision = j.prec;
      i_Num_Steps = j.steps;
      i_Num_Tiles = j.tiles;
      i_Base_Addr = j.base;
      i_Stall     = 1'b0;
      i_Start     = 1'b1;
      @(posedge CLK);
      #1;
      i_Start = 1'b0;
      for (int c = 1; c < WIN; c++) begin
         i_Stall = (c >= j.stall_from) && (c < j.stall_from + j.stall_len);
         i_Start = (c == j.restart_at);
         if (c == j.restart_at) begin
            i_Num_Tiles = 8'd3;
            i_Base_Addr = 12'h100;
         end
         #1;
         if (o_Rd_En) begin
            rd_m[c] = 1'b1;
            ea = j.base + 12'(nrd);
            chk({j.name, "_addr"}, 32'(o_Rd_Addr), 32'(ea));
            nrd++;
         end
         if (o_Core_Vld) begin
            core_m[c] = 1'b1;
            if (o_Sel_Bias) sel_b[nbeat] = 1'b1;
            if (o_Flush) flush_b[nbeat] = 1'b1;
            nbeat++;
         end else begin
            if (o_Sel_Bias) sel_b[31] = 1'b1;
            if (o_Flush) flush_b[31] = 1'b1;
         end
         psum_m[c] = o_Psum_Vld;
         busy_m[c] = o_Busy;
         done_m[c] = o_Done;
         cfg_m[c]  = o_Cfg_Err;
         if (c == 2) pout = o_Precision;
         @(posedge CLK);
         #1;
      end
      i_Stall = 1'b0;
      i_Start = 1'b0;
      chk({j.name, "_rd_en"},    rd_m,    j.rd_m);
      chk({j.name, "_core_vld"}, core_m,  j.core_m);
      chk({j.name, "_sel_bias"}, sel_b,   j.sel_b);
      chk({j.name, "_flush"},    flush_b, j.flush_b);
      chk({j.name, "_psum_vld"}, psum_m,  j.psum_m);
      chk({j.name, "_busy"},     busy_m,  j.busy_m);
      chk({j.name, "_done"},     done_m,  j.done_m);
      chk({j.name, "_cfg_err"},  cfg_m,   j.cfg_m);
      chk({j.name, "_prec_out"}, 32'(pout), 32'(j.prec_out));
   endtask

   function automatic logic [31:0] out_vec();
      return {o_Busy, o_Rd_En, o_Sel_Bias, o_Core_Vld, o_Flush, o_Psum_Vld,
              o_Cfg_Err, o_Done, o_Precision, o_Rd_Addr};
   endfunction

   initial begin
      int act;
      //            name    prec     steps  tiles base   stl ln rs rd_m      core_m    sel    flush  psum      busy      done      cfg   pout
      jobs[0] = '{"basic",  4'b1010, 10'd4, 8'd2, 12'h010, 0, 0, 0, 32'h1FE, 32'h3FC,  32'h11, 32'h88, 32'h880,  32'hFFE,  32'h1000, 32'h0, 4'hA};
      jobs[1] = '{"stall",  4'b1010, 10'd4, 8'd2, 12'h010, 3, 3, 0, 32'hFC6, 32'h1F8C, 32'h11, 32'h88, 32'h4400, 32'h7FFE, 32'h8000, 32'h0, 4'hA};
      jobs[2] = '{"step1",  4'b0101, 10'd1, 8'd3, 12'h040, 0, 0, 0, 32'hE,   32'h1C,   32'h7,  32'h7,  32'h70,   32'h7E,   32'h80,   32'h0, 4'h5};
      jobs[3] = '{"badprc", 4'b1100, 10'd4, 8'd2, 12'h000, 0, 0, 0, 32'h0,   32'h0,    32'h0,  32'h0,  32'h0,    32'h0,    32'h0,    32'h2, 4'h5};
      jobs[4] = '{"zero",   4'b0000, 10'd0, 8'd2, 12'h000, 0, 0, 0, 32'h0,   32'h0,    32'h0,  32'h0,  32'h0,    32'h0,    32'h2,    32'h0, 4'h5};
      jobs[5] = '{"wrap",   4'b0110, 10'd4, 8'd1, 12'hFFE, 0, 0, 2, 32'h1E,  32'h3C,   32'h1,  32'h8,  32'h80,   32'hFE,   32'h100,  32'h0, 4'h6};

      RST = 1'b1;
      i_Start = 1'b0;
      i_Precision = '0;
      i_Num_Steps = '0;
      i_Num_Tiles = '0;
      i_Base_Addr = '0;
      i_Stall = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_outputs", out_vec(), 32'h0);
      RST = 1'b0;

      for (int k = 0; k < 6; k++) begin
         run_job(jobs[k]);
      end

      // Abort a long job mid-issue and confirm nothing leaks out afterwards.
      @(negedge CLK);
      i_Precision = 4'b1010;
      i_Num_Steps = 10'd8;
      i_Num_Tiles = 8'd4;
      i_Base_Addr = 12'h200;
      i_Start = 1'b1;
      @(posedge CLK);
      #1;
      i_Start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      chk("midjob_busy", 32'(o_Busy), 32'h1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("midjob_reset_outputs", out_vec(), 32'h0);
      RST = 1'b0;
      act = 0;
      for (int c = 0; c < 16; c++) begin
         @(posedge CLK);
         #1;
         if (o_Psum_Vld || o_Done || o_Core_Vld || o_Rd_En || o_Busy) act++;
      end
      chk("post_reset_activity", 32'(act), 32'h0);
      run_job(jobs[2]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
